// File: rtl/iob_cache_axi_ram.sv
// AXI4 slave memory model: independent INCR read/write burst FSMs over a byte-enabled word array.
// Define AXI_RAM_STALL_EN to insert LFSR-driven ready stalls that exercise master backpressure.
module iob_cache_axi_ram #(
    parameter int BE_ADDR_W  = 32,
    parameter int BE_DATA_W  = 32,
    parameter int MEM_ADDR_W = 14,
    parameter int AXI_ID_W   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   axi_arvalid,
    input  logic [BE_ADDR_W-1:0]   axi_araddr,
    input  logic [7:0]             axi_arlen,
    input  logic [AXI_ID_W-1:0]    axi_arid,
    output logic                   axi_arready,
    output logic                   axi_rvalid,
    output logic [BE_DATA_W-1:0]   axi_rdata,
    output logic [1:0]             axi_rresp,
    output logic                   axi_rlast,
    output logic [AXI_ID_W-1:0]    axi_rid,
    input  logic                   axi_rready,
    input  logic                   axi_awvalid,
    input  logic [BE_ADDR_W-1:0]   axi_awaddr,
    input  logic [7:0]             axi_awlen,
    input  logic [AXI_ID_W-1:0]    axi_awid,
    output logic                   axi_awready,
    input  logic                   axi_wvalid,
    input  logic [BE_DATA_W-1:0]   axi_wdata,
    input  logic [BE_DATA_W/8-1:0] axi_wstrb,
    input  logic                   axi_wlast,
    output logic                   axi_wready,
    output logic                   axi_bvalid,
    output logic [1:0]             axi_bresp,
    output logic [AXI_ID_W-1:0]    axi_bid,
    input  logic                   axi_bready
);
    localparam int BE_BYTE_W = $clog2(BE_DATA_W / 8);
    localparam int STRB_W    = BE_DATA_W / 8;
    localparam logic [MEM_ADDR_W-1:0] IDX_ONE = 1;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [BE_DATA_W-1:0] mem [0:(2**MEM_ADDR_W)-1];

    r_state_t              r_state, r_state_nxt;
    w_state_t              w_state, w_state_nxt;
    logic [MEM_ADDR_W-1:0] r_idx, w_idx;
    logic [7:0]            r_cnt, w_len;
    logic [8:0]            w_cnt;
    logic                  stall;
    logic                  ar_hs, r_hs, aw_hs, w_hs, w_in_range;
    logic                  unused_addr_bits;

`ifdef AXI_RAM_STALL_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= 8'hA5;
        else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    // Address bits above the word index and below the data width are ignored.
    assign unused_addr_bits = ^{axi_araddr, axi_awaddr};
    assign axi_rresp = 2'b00;

    always_comb begin
        r_state_nxt = r_state;
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        axi_rlast   = 1'b0;
        case (r_state)
            R_IDLE: begin
                axi_arready = ~stall;
                if (axi_arvalid && !stall) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                axi_rvalid = 1'b1;
                axi_rlast  = (r_cnt == 8'd0);
                if (axi_rready && r_cnt == 8'd0) r_state_nxt = R_IDLE;
            end
        endcase
    end

    assign ar_hs = axi_arvalid & axi_arready;
    assign r_hs  = axi_rvalid & axi_rready;

    // The next word is fetched on the same edge a beat is accepted, so bursts run at full rate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= R_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            axi_rid   <= '0;
            axi_rdata <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) begin
                r_idx     <= axi_araddr[BE_BYTE_W +: MEM_ADDR_W];
                r_cnt     <= axi_arlen;
                axi_rid   <= axi_arid;
                axi_rdata <= mem[axi_araddr[BE_BYTE_W +: MEM_ADDR_W]];
            end else if (r_hs && r_cnt != 8'd0) begin
                r_idx     <= r_idx + IDX_ONE;
                r_cnt     <= r_cnt - 8'd1;
                axi_rdata <= mem[r_idx + IDX_ONE];
            end
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                axi_awready = ~stall;
                if (axi_awvalid && !stall) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                axi_wready = ~stall;
                if (axi_wvalid && !stall && axi_wlast) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                axi_bvalid = 1'b1;
                if (axi_bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign aw_hs      = axi_awvalid & axi_awready;
    assign w_hs       = axi_wvalid & axi_wready;
    assign w_in_range = (w_cnt <= {1'b0, w_len});

    // Beat counter saturates so an overlong burst can never alias back to a legal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state   <= W_IDLE;
            w_idx     <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            axi_bid   <= '0;
            axi_bresp <= 2'b00;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) begin
                w_idx   <= axi_awaddr[BE_BYTE_W +: MEM_ADDR_W];
                w_len   <= axi_awlen;
                w_cnt   <= '0;
                axi_bid <= axi_awid;
            end else if (w_hs) begin
                w_idx <= w_idx + IDX_ONE;
                if (w_cnt != 9'h1FF) w_cnt <= w_cnt + 9'd1;
                if (axi_wlast) axi_bresp <= (w_cnt == {1'b0, w_len}) ? 2'b00 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs && w_in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_wstrb[b]) mem[w_idx][8*b +: 8] <= axi_wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: doc/iob_cache_axi_ram.md
Name: iob_cache_axi_ram

Overview:
- AXI4 slave memory model: the responder end of the cache's AXI back-end.
- Accepts INCR read and write bursts from an AXI master and serves them from an internal byte-enabled word array.
- Used as the system-memory stand-in for cache simulation and FPGA bring-up.
- Read and write channels run independent FSMs over a dual-port array; one outstanding transaction per direction.

Parameters:
- BE_ADDR_W, 32, AXI byte-address width.
- BE_DATA_W, 32, AXI data width (32 or 64).
- MEM_ADDR_W, 14, log2 of array depth in BE_DATA_W words.
- AXI_ID_W, 1, AXI ID width.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- axi_arvalid  in  1  read address valid
- axi_araddr  in  BE_ADDR_W  read byte address
- axi_arlen  in  8  read beats minus 1
- axi_arid  in  AXI_ID_W  read ID
- axi_arready  out  1  read address accept
- axi_rvalid  out  1  read data valid
- axi_rdata  out  BE_DATA_W  read data
- axi_rresp  out  2  always 2'b00
- axi_rlast  out  1  final read beat
- axi_rid  out  AXI_ID_W  latched arid
- axi_rready  in  1  master accepts read beat
- axi_awvalid  in  1  write address valid
- axi_awaddr  in  BE_ADDR_W  write byte address
- axi_awlen  in  8  write beats minus 1
- axi_awid  in  AXI_ID_W  write ID
- axi_awready  out  1  write address accept
- axi_wvalid  in  1  write data valid
- axi_wdata  in  BE_DATA_W  write data
- axi_wstrb  in  BE_DATA_W/8  byte enables
- axi_wlast  in  1  final write beat
- axi_wready  out  1  write data accept
- axi_bvalid  out  1  write response valid
- axi_bresp  out  2  write response
- axi_bid  out  AXI_ID_W  latched awid
- axi_bready  in  1  master accepts response
- (arsize/arburst/arlock/arcache/arprot/arqos and aw equivalents: not ported; every burst is treated as INCR at full width.)

Behaviour:
- Word index = addr[BE_BYTE_W +: MEM_ADDR_W]; upper bits ignored. Index increments per beat modulo 2^MEM_ADDR_W (wraps to 0).
- Reset values: arready=1, awready=1, wready=0, rvalid=0, rlast=0, rdata=0, bvalid=0, bresp=0, rid=0, bid=0. Array contents are not reset.
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On arvalid, latch index, len count and id; array read issued.
  - R_DATA is entered the next cycle with rvalid=1 and rdata=mem[index]. First-beat latency is 1 cycle after the AR handshake.
  - R_DATA: arready=0. rvalid, rdata and rlast hold stable while rready=0.
  - On rvalid&rready with count!=0: index+1, count-1, rdata<=mem[index+1] the same edge. Full throughput.
  - rlast=1 exactly when count==0. The beat handshake with rlast -> R_IDLE, rvalid=0.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1, wready=0. On awvalid, latch index, len and id -> W_DATA.
  - W_DATA: wready=1. Each wvalid&wready writes the bytes where wstrb=1, increments index and increments the beat counter.
  - Beats after the (awlen+1)th are not written but are still accepted.
  - The beat with wlast -> W_RESP.
  - bresp=2'b10 (SLVERR) if the received beat count != awlen+1; otherwise 2'b00.
  - W_RESP: bvalid=1, wready=0, until bready -> W_IDLE.
- Same-word read and write in one cycle: the read returns the old data (read-before-write).
- AR and AW handshakes may occur in the same cycle; the channels are independent.
- Asserting reset mid-burst aborts both FSMs to IDLE immediately. Partially written words remain.

Optional Feature:
- Macro: AXI_RAM_STALL_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle.
  - LFSR bit0=1 forces arready, awready and wready to 0 that cycle.
  - rvalid/bvalid are never withdrawn once asserted.
  - Purpose: exercises master backpressure.
- When undefined: no LFSR; readies follow the FSMs alone.

Test Plan:
- Write 1 beat at 0x100, wdata 0xDEADBEEF, wstrb 4'hF; then read len 0 at 0x100 -> rvalid 1 cycle after AR, rdata 0xDEADBEEF, rlast=1, rresp=0, bresp=0.
- 8-beat write at 0x200 (data 0..7); 8-beat read with rready toggling 1/0 -> rdata 0..7 in order, held stable while stalled, rlast on beat 8 only.
- Write 0xFFFFFFFF then 0x00000000 with wstrb 4'b0101 to 0x40 -> readback 0xFF00FF00.
- 4-beat write at word 2^MEM_ADDR_W-2 -> words 2^MEM_ADDR_W-2, 2^MEM_ADDR_W-1, 0, 1 hold the beats in order.
- awlen=3, wlast on beat 2 -> bresp=2'b10, bvalid held until bready; next burst accepted normally.
- Reset asserted mid 8-beat read -> rvalid=0 and arready=1 asynchronously; a new AR after reset is served correctly.
